// File: rtl/reg_file_pkg.sv
// Register-file map shared by the AXI-Lite slave and its address decoder:
// table layout, AXI response codes, slave FSM states and the address lookup.
package reg_file_pkg;

  localparam int REG_FILE_AXI_ADDR_WIDTH = 8;
  localparam int REG_FILE_NUM_REGISTERS  = 4;
  localparam int REG_FILE_ID_WIDTH       = $clog2(REG_FILE_NUM_REGISTERS);

  typedef logic [REG_FILE_ID_WIDTH-1:0] reg_file_id_t;

  typedef struct packed {
    logic                               entry_found;
    logic                               memory_mapped;
    logic                               trigger_on_write;
    logic                               clear_on_read;
    reg_file_id_t                       id;
    logic [REG_FILE_AXI_ADDR_WIDTH-1:0] addr;
  } reg_file_item_t;

  // Entry 3 is described in the map but has no storage behind the bus.
  localparam reg_file_item_t REG_MAP_TABLE [REG_FILE_NUM_REGISTERS] = '{
    '{entry_found: 1'b1, memory_mapped: 1'b1, trigger_on_write: 1'b0,
      clear_on_read: 1'b0, id: reg_file_id_t'(0), addr: 8'h00},
    '{entry_found: 1'b1, memory_mapped: 1'b1, trigger_on_write: 1'b1,
      clear_on_read: 1'b0, id: reg_file_id_t'(1), addr: 8'h04},
    '{entry_found: 1'b1, memory_mapped: 1'b1, trigger_on_write: 1'b0,
      clear_on_read: 1'b1, id: reg_file_id_t'(2), addr: 8'h08},
    '{entry_found: 1'b1, memory_mapped: 1'b0, trigger_on_write: 1'b0,
      clear_on_read: 1'b0, id: reg_file_id_t'(3), addr: 8'h0C}
  };

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WR_RESP,
    RD_WAIT,
    RD_RESP
  } reg_file_state_e;

  // Word-aligned address in, matching table entry out; all-zero item on a miss.
  function automatic reg_file_item_t reg_file_addr2item(input logic [63:0] addr);
    reg_file_item_t item;
    item = '0;
    for (int i = 0; i < REG_FILE_NUM_REGISTERS; i++) begin
      if (64'(REG_MAP_TABLE[i].addr) == addr) item = REG_MAP_TABLE[i];
    end
    return item;
  endfunction

endpackage

// File: rtl/reg_file_addr_decoder.sv
// Combinational register-map lookup; the slave feeds it whichever of
// AWADDR/ARADDR is being granted this cycle.
module reg_file_addr_decoder
  import reg_file_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = REG_FILE_AXI_ADDR_WIDTH
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  output logic                      hit,
  output reg_file_id_t              id,
  output logic                      trigger_on_write,
  output logic                      clear_on_read
);

  logic [63:0]    addr_aligned;
  reg_file_item_t item;

  always_comb begin
    addr_aligned     = 64'(addr) & ~64'h3;
    item             = reg_file_addr2item(addr_aligned);
    hit              = item.entry_found && item.memory_mapped &&
                       (64'(item.addr) == addr_aligned);
    id               = item.id;
    trigger_on_write = item.trigger_on_write;
    clear_on_read    = item.clear_on_read;
  end

endmodule

// File: rtl/axi_lite_reg_file_slave.sv
// AXI-Lite slave in front of a register file: one transaction at a time,
// round-robin between read and write, single-cycle storage strobes.
module axi_lite_reg_file_slave
  import reg_file_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = REG_FILE_AXI_ADDR_WIDTH,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [AXI_ADDR_WIDTH-1:0]         s_axi_awaddr,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]         s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]       s_axi_wstrb,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]         s_axi_araddr,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]         s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output reg_file_id_t                      reg_id,
  output logic                              reg_wr_en,
  output logic [AXI_DATA_WIDTH-1:0]         reg_wr_data,
  output logic [AXI_DATA_WIDTH/8-1:0]       reg_wr_strb,
  output logic [REG_FILE_NUM_REGISTERS-1:0] reg_trigger,
  output logic                              reg_rd_en,
  output logic                              reg_rd_clear,
  input  logic [AXI_DATA_WIDTH-1:0]         reg_rd_data
);

  reg_file_state_e             state_q, state_d;
  logic                        last_grant_wr_q, last_grant_wr_d;
  logic                        rd_hit_q, rd_hit_d;
  logic [1:0]                  resp_q, resp_d;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                        wr_elig, rd_elig, grant_wr, grant_rd;
  logic [AXI_ADDR_WIDTH-1:0]   dec_addr;
  logic                        dec_hit, dec_trig, dec_clear;
  reg_file_id_t                dec_id;

  // Grants are held off while rst is high so no handshake or strobe escapes.
  always_comb begin
    wr_elig  = (state_q == IDLE) && !rst && s_axi_awvalid && s_axi_wvalid;
    rd_elig  = (state_q == IDLE) && !rst && s_axi_arvalid;
    grant_wr = wr_elig && (!rd_elig || !last_grant_wr_q);
    grant_rd = rd_elig && !grant_wr;
    dec_addr = grant_rd ? s_axi_araddr : s_axi_awaddr;
  end

  reg_file_addr_decoder #(
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH)
  ) u_decoder (
    .addr             (dec_addr),
    .hit              (dec_hit),
    .id               (dec_id),
    .trigger_on_write (dec_trig),
    .clear_on_read    (dec_clear)
  );

  always_comb begin
    state_d         = state_q;
    last_grant_wr_d = last_grant_wr_q;
    rd_hit_d        = rd_hit_q;
    resp_d          = resp_q;
    rdata_d         = rdata_q;
    s_axi_awready   = 1'b0;
    s_axi_wready    = 1'b0;
    s_axi_arready   = 1'b0;
    s_axi_bvalid    = 1'b0;
    s_axi_rvalid    = 1'b0;
    reg_wr_en       = 1'b0;
    reg_trigger     = '0;
    reg_rd_en       = 1'b0;
    reg_rd_clear    = 1'b0;
    reg_id          = dec_id;
    reg_wr_data     = s_axi_wdata;
    reg_wr_strb     = s_axi_wstrb;

    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          s_axi_awready   = 1'b1;
          s_axi_wready    = 1'b1;
          reg_wr_en       = dec_hit;
          reg_trigger     = (dec_hit && dec_trig) ?
                            (REG_FILE_NUM_REGISTERS'(1) << dec_id) : '0;
          resp_d          = dec_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
          last_grant_wr_d = 1'b1;
          state_d         = WR_RESP;
        end else if (grant_rd) begin
          s_axi_arready   = 1'b1;
          reg_rd_en       = dec_hit;
          reg_rd_clear    = dec_hit && dec_clear;
          rd_hit_d        = dec_hit;
          resp_d          = dec_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
          last_grant_wr_d = 1'b0;
          state_d         = RD_WAIT;
        end
      end
      WR_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) state_d = IDLE;
      end
      // Storage returns data one cycle after reg_rd_en.
      RD_WAIT: begin
        rdata_d = rd_hit_q ? reg_rd_data : '0;
        state_d = RD_RESP;
      end
      RD_RESP: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_axi_bresp = resp_q;
  assign s_axi_rresp = resp_q;
  assign s_axi_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      last_grant_wr_q <= 1'b0;
      rd_hit_q        <= 1'b0;
      resp_q          <= '0;
      rdata_q         <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_wr_q <= last_grant_wr_d;
      rd_hit_q        <= rd_hit_d;
      resp_q          <= resp_d;
      rdata_q         <= rdata_d;
    end
  end

endmodule
